// File: rtl/boss_pkg.sv
// Shared types and constants for the boss attack sequencer.
// Holds FSM/pattern types, spread tables, step constants and the aim helper.
package boss_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COOLDOWN,
    FIRE_SPREAD,
    FIRE_AIMED,
    FIRE_BURST
  } fire_state_t;

  typedef logic [1:0] pattern_t;

  localparam pattern_t PAT_SPREAD = 2'd0;
  localparam pattern_t PAT_AIMED  = 2'd1;
  localparam pattern_t PAT_BURST  = 2'd2;

  // Slot 3 .. slot 0, 3 bits each.
  localparam logic [11:0] SPREAD_X   = {3'd2, 3'd1, 3'd1, 3'd2};
  localparam logic [3:0]  SPREAD_NEG = 4'b0011;
  localparam logic [2:0]  SPREAD_Y   = 3'd3;

  localparam logic [2:0] AIMED_Y     = 3'd4;
  localparam logic [2:0] AIMED_X_MAX = 3'd4;
  localparam logic [2:0] BURST_X     = 3'd0;
  localparam logic [2:0] BURST_Y     = 3'd5;

  // Clamp is applied on the full quotient so large dx never wraps.
  function automatic logic [2:0] aim_step(
    input logic [9:0] boss_x,
    input logic [9:0] ship_x
  );
    logic [9:0] dx;
    logic [9:0] q;
    dx = (ship_x < boss_x) ? (boss_x - ship_x)
                           : (ship_x - boss_x);
    q  = dx >> 6;
    return (q > {7'd0, AIMED_X_MAX}) ? AIMED_X_MAX
                                     : q[2:0];
  endfunction

endpackage

// File: rtl/boss_fire_ctrl_frame_edge_det.sv
// frame_edge_det: two-flop rising-edge detector for frame_clk.
// Ports: Clk, Reset (sync, high), frame_clk in; frame_tick out (1-cycle pulse).
module frame_edge_det (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic frame_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_d    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_d    <= frame_clk;
      frame_tick <= frame_clk & ~frame_d;
    end
  end

endmodule

// File: rtl/boss_fire_ctrl.sv
// boss_fire_ctrl: per-frame boss attack sequencer driving projectile slots.
// In: Clk, Reset, frame_clk, enable, boss/ship x, slot_idle.
// Out: shoot, x_step, y_step, negative_x per slot; pattern; busy.
module boss_fire_ctrl
  import boss_pkg::*;
#(
  parameter int NUM_SLOTS       = 4,
  parameter int COOLDOWN_FRAMES = 60,
  parameter int BURST_GAP       = 8,
  parameter int BURST_LEN       = 3
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_clk,
  input  logic                   enable,
  input  logic [9:0]             boss_x_pos,
  input  logic [9:0]             ship_x_pos,
  input  logic [NUM_SLOTS-1:0]   slot_idle,
  output logic [NUM_SLOTS-1:0]   shoot,
  output logic [3*NUM_SLOTS-1:0] x_step,
  output logic [3*NUM_SLOTS-1:0] y_step,
  output logic [NUM_SLOTS-1:0]   negative_x,
  output pattern_t               pattern,
  output logic                   busy
);

  localparam logic [7:0] CD_LOAD   = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0] GAP_LOAD  = 8'(BURST_GAP);
  localparam logic [7:0] LAST_SHOT = 8'(BURST_LEN - 1);

  fire_state_t            state;
  fire_state_t            fire_state;
  logic [7:0]             cnt;
  logic [7:0]             shots;
  logic [NUM_SLOTS-1:0]   reserved;
  logic [NUM_SLOTS-1:0]   free;
  logic [NUM_SLOTS-1:0]   lowest;
  logic [NUM_SLOTS-1:0]   issue;
  logic [NUM_SLOTS-1:0]   new_neg;
  logic [3*NUM_SLOTS-1:0] new_x;
  logic [3*NUM_SLOTS-1:0] new_y;
  logic [2:0]             aim_x;
  logic                   aim_neg;
  logic                   frame_tick;

  frame_edge_det u_edge (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  // A slot just issued still reads idle for one frame.
  assign free    = slot_idle & ~reserved;
  assign aim_x   = aim_step(boss_x_pos, ship_x_pos);
  assign aim_neg = ship_x_pos < boss_x_pos;
  assign busy    = (state == FIRE_SPREAD) ||
                   (state == FIRE_AIMED)  ||
                   (state == FIRE_BURST);

  always_comb begin
    lowest = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (free[i]) begin
        lowest    = '0;
        lowest[i] = 1'b1;
      end
    end
  end

  always_comb begin
    unique case (pattern)
      PAT_AIMED: fire_state = FIRE_AIMED;
      PAT_BURST: fire_state = FIRE_BURST;
      default:   fire_state = FIRE_SPREAD;
    endcase
  end

  always_comb begin
    issue   = '0;
    new_x   = '0;
    new_y   = '0;
    new_neg = '0;
    if (frame_tick) begin
      unique case (state)
        FIRE_SPREAD:
          if (&slot_idle && reserved == '0)
            issue = '1;
        FIRE_AIMED: issue = lowest;
        FIRE_BURST:
          if (cnt == 8'd0)
            issue = lowest;
        default: issue = '0;
      endcase
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      unique case (state)
        FIRE_SPREAD: begin
          new_x[3*i +: 3] = SPREAD_X[3*(i%4) +: 3];
          new_y[3*i +: 3] = SPREAD_Y;
          new_neg[i]      = SPREAD_NEG[i%4];
        end
        FIRE_AIMED: begin
          new_x[3*i +: 3] = aim_x;
          new_y[3*i +: 3] = AIMED_Y;
          new_neg[i]      = aim_neg;
        end
        FIRE_BURST: begin
          new_x[3*i +: 3] = BURST_X;
          new_y[3*i +: 3] = BURST_Y;
          new_neg[i]      = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shots      <= '0;
      reserved   <= '0;
      shoot      <= '0;
      x_step     <= '0;
      y_step     <= '0;
      negative_x <= '0;
      pattern    <= PAT_SPREAD;
    end else if (!enable) begin
      state <= IDLE;
      cnt   <= '0;
      shots <= '0;
      shoot <= '0;
    end else if (state == IDLE) begin
      state <= COOLDOWN;
      cnt   <= CD_LOAD;
    end else if (frame_tick) begin
      // shoot spans exactly one frame: set here, cleared next tick.
      shoot    <= issue;
      reserved <= (reserved & slot_idle) | issue;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (issue[i]) begin
          x_step[3*i +: 3] <= new_x[3*i +: 3];
          y_step[3*i +: 3] <= new_y[3*i +: 3];
          negative_x[i]    <= new_neg[i];
        end
      end
      unique case (state)
        COOLDOWN: begin
          if (cnt <= 8'd1) begin
            state <= fire_state;
            cnt   <= '0;
            shots <= '0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        FIRE_SPREAD: begin
          if (|issue) begin
            state   <= COOLDOWN;
            cnt     <= CD_LOAD;
            pattern <= PAT_AIMED;
          end
        end
        FIRE_AIMED: begin
          if (|issue) begin
            state   <= COOLDOWN;
            cnt     <= CD_LOAD;
            pattern <= PAT_BURST;
          end
        end
        FIRE_BURST: begin
          // Gap holds at 0 while no slot is free.
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (|issue) begin
            if (shots == LAST_SHOT) begin
              state   <= COOLDOWN;
              cnt     <= CD_LOAD;
              shots   <= '0;
              pattern <= PAT_SPREAD;
            end else begin
              shots <= shots + 8'd1;
              cnt   <= GAP_LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boss_fire_ctrl.sv
// Testbench for boss_fire_ctrl: table of per-frame vectors plus
// hand sequences for enable drop and reset during a shot.
module tb_boss_fire_ctrl;

  logic        Clk;
  logic        Reset;
  logic        frame_clk;
  logic        enable;
  logic [9:0]  boss_x_pos;
  logic [9:0]  ship_x_pos;
  logic [3:0]  slot_idle;
  logic [3:0]  shoot;
  logic [11:0] x_step;
  logic [11:0] y_step;
  logic [3:0]  negative_x;
  logic [1:0]  pattern;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  idle;
    logic [9:0]  ship;
    logic [3:0]  e_shoot;
    logic [11:0] e_x;
    logic [11:0] e_y;
    logic [3:0]  e_neg;
    logic [1:0]  e_pat;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  boss_fire_ctrl #(
    .NUM_SLOTS       (4),
    .COOLDOWN_FRAMES (3),
    .BURST_GAP       (2),
    .BURST_LEN       (3)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .enable     (enable),
    .boss_x_pos (boss_x_pos),
    .ship_x_pos (ship_x_pos),
    .slot_idle  (slot_idle),
    .shoot      (shoot),
    .x_step     (x_step),
    .y_step     (y_step),
    .negative_x (negative_x),
    .pattern    (pattern),
    .busy       (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic check_out(
    input string       tag,
    input logic [3:0]  e_shoot,
    input logic [11:0] e_x,
    input logic [11:0] e_y,
    input logic [3:0]  e_neg,
    input logic [1:0]  e_pat,
    input logic        e_busy
  );
    n_chk++;
    if (shoot !== e_shoot) begin
      n_fail++;
      $display("FAIL %s shoot: got %b expected %b", tag, shoot, e_shoot);
    end
    n_chk++;
    if (x_step !== e_x) begin
      n_fail++;
      $display("FAIL %s x_step: got %h expected %h", tag, x_step, e_x);
    end
    n_chk++;
    if (y_step !== e_y) begin
      n_fail++;
      $display("FAIL %s y_step: got %h expected %h", tag, y_step, e_y);
    end
    n_chk++;
    if (negative_x !== e_neg) begin
      n_fail++;
      $display("FAIL %s negative_x: got %b expected %b", tag, negative_x, e_neg);
    end
    n_chk++;
    if (pattern !== e_pat) begin
      n_fail++;
      $display("FAIL %s pattern: got %0d expected %0d", tag, pattern, e_pat);
    end
    n_chk++;
    if (busy !== e_busy) begin
      n_fail++;
      $display("FAIL %s busy: got %b expected %b", tag, busy, e_busy);
    end
  endtask

  initial begin
    // Cooldown -> spread
    vecs.push_back('{4'b1111, 10'd100, 4'b0000, 12'h000, 12'h000, 4'b0000, 2'd0, 1'b0});
    vecs.push_back('{4'b1111, 10'd100, 4'b0000, 12'h000, 12'h000, 4'b0000, 2'd0, 1'b0});
    vecs.push_back('{4'b1111, 10'd100, 4'b0000, 12'h000, 12'h000, 4'b0000, 2'd0, 1'b1});
    vecs.push_back('{4'b1111, 10'd100, 4'b1111, 12'h44A, 12'h6DB, 4'b0011, 2'd1, 1'b0});
    // Cooldown -> aimed, ship left of boss
    vecs.push_back('{4'b1111, 10'd100, 4'b0000, 12'h44A, 12'h6DB, 4'b0011, 2'd1, 1'b0});
    vecs.push_back('{4'b0000, 10'd100, 4'b0000, 12'h44A, 12'h6DB, 4'b0011, 2'd1, 1'b0});
    vecs.push_back('{4'b0000, 10'd100, 4'b0000, 12'h44A, 12'h6DB, 4'b0011, 2'd1, 1'b1});
    vecs.push_back('{4'b0000, 10'd100, 4'b0000, 12'h44A, 12'h6DB, 4'b0011, 2'd1, 1'b1});
    vecs.push_back('{4'b0100, 10'd100, 4'b0100, 12'h4CA, 12'h71B, 4'b0111, 2'd2, 1'b0});
    // Cooldown -> burst, slot0 lags idle for two frames
    vecs.push_back('{4'b0100, 10'd100, 4'b0000, 12'h4CA, 12'h71B, 4'b0111, 2'd2, 1'b0});
    vecs.push_back('{4'b0000, 10'd100, 4'b0000, 12'h4CA, 12'h71B, 4'b0111, 2'd2, 1'b0});
    vecs.push_back('{4'b0000, 10'd100, 4'b0000, 12'h4CA, 12'h71B, 4'b0111, 2'd2, 1'b1});
    vecs.push_back('{4'b0011, 10'd100, 4'b0001, 12'h4C8, 12'h71D, 4'b0110, 2'd2, 1'b1});
    vecs.push_back('{4'b0011, 10'd100, 4'b0000, 12'h4C8, 12'h71D, 4'b0110, 2'd2, 1'b1});
    vecs.push_back('{4'b0011, 10'd100, 4'b0000, 12'h4C8, 12'h71D, 4'b0110, 2'd2, 1'b1});
    vecs.push_back('{4'b0011, 10'd100, 4'b0010, 12'h4C0, 12'h72D, 4'b0100, 2'd2, 1'b1});
    vecs.push_back('{4'b0011, 10'd100, 4'b0000, 12'h4C0, 12'h72D, 4'b0100, 2'd2, 1'b1});
    vecs.push_back('{4'b0000, 10'd100, 4'b0000, 12'h4C0, 12'h72D, 4'b0100, 2'd2, 1'b1});
    vecs.push_back('{4'b0000, 10'd100, 4'b0000, 12'h4C0, 12'h72D, 4'b0100, 2'd2, 1'b1});
    vecs.push_back('{4'b1000, 10'd100, 4'b1000, 12'h0C0, 12'hB2D, 4'b0100, 2'd0, 1'b0});
    // Cooldown -> spread blocked by busy slot2
    vecs.push_back('{4'b1000, 10'd100, 4'b0000, 12'h0C0, 12'hB2D, 4'b0100, 2'd0, 1'b0});
    vecs.push_back('{4'b0011, 10'd100, 4'b0000, 12'h0C0, 12'hB2D, 4'b0100, 2'd0, 1'b0});
    vecs.push_back('{4'b1011, 10'd100, 4'b0000, 12'h0C0, 12'hB2D, 4'b0100, 2'd0, 1'b1});
    vecs.push_back('{4'b1011, 10'd100, 4'b0000, 12'h0C0, 12'hB2D, 4'b0100, 2'd0, 1'b1});
    vecs.push_back('{4'b1111, 10'd100, 4'b1111, 12'h44A, 12'h6DB, 4'b0011, 2'd1, 1'b0});
    // Aimed with clamp, ship far right
    vecs.push_back('{4'b1111, 10'd639, 4'b0000, 12'h44A, 12'h6DB, 4'b0011, 2'd1, 1'b0});
    vecs.push_back('{4'b0000, 10'd639, 4'b0000, 12'h44A, 12'h6DB, 4'b0011, 2'd1, 1'b0});
    vecs.push_back('{4'b0000, 10'd639, 4'b0000, 12'h44A, 12'h6DB, 4'b0011, 2'd1, 1'b1});
    vecs.push_back('{4'b1111, 10'd639, 4'b0001, 12'h44C, 12'h6DC, 4'b0010, 2'd2, 1'b0});
    // Into burst, first shot on slot1
    vecs.push_back('{4'b1111, 10'd639, 4'b0000, 12'h44C, 12'h6DC, 4'b0010, 2'd2, 1'b0});
    vecs.push_back('{4'b1110, 10'd639, 4'b0000, 12'h44C, 12'h6DC, 4'b0010, 2'd2, 1'b0});
    vecs.push_back('{4'b1110, 10'd639, 4'b0000, 12'h44C, 12'h6DC, 4'b0010, 2'd2, 1'b1});
    vecs.push_back('{4'b1110, 10'd639, 4'b0010, 12'h444, 12'h6EC, 4'b0000, 2'd2, 1'b1});

    Reset      = 1'b1;
    enable     = 1'b1;
    frame_clk  = 1'b0;
    boss_x_pos = 10'd320;
    ship_x_pos = 10'd100;
    slot_idle  = 4'b1111;
    repeat (3) @(negedge Clk);
    check_out("reset", 4'b0000, 12'h000, 12'h000, 4'b0000, 2'd0, 1'b0);
    Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      slot_idle  = vecs[i].idle;
      ship_x_pos = vecs[i].ship;
      tick();
      check_out($sformatf("row%0d", i + 1), vecs[i].e_shoot,
                vecs[i].e_x, vecs[i].e_y, vecs[i].e_neg,
                vecs[i].e_pat, vecs[i].e_busy);
    end

    // Disable mid-burst, then resume with pattern kept.
    slot_idle = 4'b1111;
    enable    = 1'b0;
    @(negedge Clk);
    check_out("disable", 4'b0000, 12'h444, 12'h6EC, 4'b0000, 2'd2, 1'b0);
    enable = 1'b1;
    tick();
    check_out("reen1", 4'b0000, 12'h444, 12'h6EC, 4'b0000, 2'd2, 1'b0);
    tick();
    check_out("reen2", 4'b0000, 12'h444, 12'h6EC, 4'b0000, 2'd2, 1'b0);
    tick();
    check_out("reen3", 4'b0000, 12'h444, 12'h6EC, 4'b0000, 2'd2, 1'b1);
    tick();
    check_out("reen4", 4'b0001, 12'h440, 12'h6ED, 4'b0000, 2'd2, 1'b1);

    // Reset while shoot is high.
    Reset = 1'b1;
    @(negedge Clk);
    check_out("rst_hi", 4'b0000, 12'h000, 12'h000, 4'b0000, 2'd0, 1'b0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    tick();
    check_out("post1", 4'b0000, 12'h000, 12'h000, 4'b0000, 2'd0, 1'b0);
    tick();
    check_out("post2", 4'b0000, 12'h000, 12'h000, 4'b0000, 2'd0, 1'b0);
    tick();
    check_out("post3", 4'b0000, 12'h000, 12'h000, 4'b0000, 2'd0, 1'b1);
    tick();
    check_out("post4", 4'b1111, 12'h44A, 12'h6DB, 4'b0011, 2'd1, 1'b0);
    tick();
    check_out("post5", 4'b0000, 12'h44A, 12'h6DB, 4'b0011, 2'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
